// File: rtl/dm_port_arbiter_pkg.sv
// dm_port_arbiter_pkg
//   Shared definitions for the data-memory port arbiter: bus widths,
//   the write-disable level, the arbiter state encoding and the
//   saturating conflict-counter increment.
package dm_port_arbiter_pkg;

    localparam int          DATA_BUS        = 32;
    localparam int          MEM_ADDR_BUS    = 32;
    localparam logic        DMWRITE_DISABLE = 1'b0;
    localparam logic [31:0] DATA_INITIAL    = 32'h0000_0000;
    localparam logic [31:0] CNT_MAX         = 32'hFFFF_FFFF;

    // ARB_IDLE: no pending access (reset state).
    // ARB_SECOND: older access done, younger access being served.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_SECOND = 1'b1
    } arb_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dm_port_mux.sv
// dm_port_mux
//   Purely combinational selection of one lane's access onto the single
//   data-memory port. With en low the port is parked at all zeros.
// Ports:
//   en                      drive the port at all
//   sel                     0 = lane 0, 1 = lane 1
//   lX_we/wea/addr/wdata    lane access fields
//   mem_w/DWea/Addr_out/Data_out  memory port
module dm_port_mux
    import dm_port_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            en,
    input  logic            sel,
    input  logic            l0_we,
    input  logic [DW/8-1:0] l0_wea,
    input  logic [AW-1:0]   l0_addr,
    input  logic [DW-1:0]   l0_wdata,
    input  logic            l1_we,
    input  logic [DW/8-1:0] l1_wea,
    input  logic [AW-1:0]   l1_addr,
    input  logic [DW-1:0]   l1_wdata,
    output logic            mem_w,
    output logic [DW/8-1:0] DWea,
    output logic [AW-1:0]   Addr_out,
    output logic [DW-1:0]   Data_out
);

    always_comb begin
        mem_w    = DMWRITE_DISABLE;
        DWea     = '0;
        Addr_out = '0;
        Data_out = '0;
        if (en) begin
            if (sel) begin
                mem_w    = l1_we;
                DWea     = l1_we ? l1_wea : '0;
                Addr_out = l1_addr;
                Data_out = l1_wdata;
            end else begin
                mem_w    = l0_we;
                DWea     = l0_we ? l0_wea : '0;
                Addr_out = l0_addr;
                Data_out = l0_wdata;
            end
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single data-memory port between the two execution lanes.
//   A lone request goes straight to the port with no added latency. Two
//   same-cycle requests are serialised oldest first: the older access is
//   performed while stall_out is raised and its read word is captured in
//   rbuf, then the younger access is performed in SECOND. Lanes receive the
//   raw read word; sign extension happens in the lanes.
//   Internal signal "state" (arb_state_t) is the FSM state for debug.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stop_in                 pipeline freeze; holds the current state
//   lX_req/we/wea/addr/wdata/num   lane access; num = 0 marks the older lane
//   mem_w/DWea/Addr_out/Data_out   memory port
//   Data_in                 memory read data (combinational from Addr_out)
//   lX_rdata                raw read word per lane
//   stall_out               one-cycle stall while the older access runs
//   conflict_cnt            saturating count of serialised conflicts
//
// Handshake: a lane request is qualified by lX_req alone; the pipeline holds
// lane inputs stable while stall_out or stop_in is high, so nothing is
// re-registered here. A state only advances in a cycle with stop_in low.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stop_in,
    input  logic            l0_req,
    input  logic            l0_we,
    input  logic [DW/8-1:0] l0_wea,
    input  logic [AW-1:0]   l0_addr,
    input  logic [DW-1:0]   l0_wdata,
    input  logic            l0_num,
    input  logic            l1_req,
    input  logic            l1_we,
    input  logic [DW/8-1:0] l1_wea,
    input  logic [AW-1:0]   l1_addr,
    input  logic [DW-1:0]   l1_wdata,
    input  logic            l1_num,
    output logic            mem_w,
    output logic [DW/8-1:0] DWea,
    output logic [AW-1:0]   Addr_out,
    output logic [DW-1:0]   Data_out,
    input  logic [DW-1:0]   Data_in,
    output logic [DW-1:0]   l0_rdata,
    output logic [DW-1:0]   l1_rdata,
    output logic            stall_out,
    output logic [31:0]     conflict_cnt
);

    arb_state_t    state, state_nxt;
    logic [DW-1:0] rbuf;
    logic [31:0]   cnt_q;
    logic          grant;
    logic          port_en;
    logic          stall;
    logic          capture;
    logic          older_is_l1;
    logic          both_req;

    // Lane 1 is older only when it alone carries num = 0; a tie goes to lane 0.
    assign older_is_l1 = l0_num & ~l1_num;
    assign both_req    = l0_req & l1_req;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        port_en   = 1'b0;
        stall     = 1'b0;
        capture   = 1'b0;
        l0_rdata  = '0;
        l1_rdata  = '0;
        case (state)
            ARB_IDLE: begin
                if (both_req) begin
                    grant   = older_is_l1;
                    port_en = 1'b1;
                    stall   = 1'b1;
                    if (older_is_l1) l1_rdata = Data_in;
                    else             l0_rdata = Data_in;
                    if (!stop_in) begin
                        capture   = 1'b1;
                        state_nxt = ARB_SECOND;
                    end
                end else if (l0_req) begin
                    port_en  = 1'b1;
                    l0_rdata = Data_in;
                end else if (l1_req) begin
                    grant    = 1'b1;
                    port_en  = 1'b1;
                    l1_rdata = Data_in;
                end
            end
            ARB_SECOND: begin
                grant   = ~older_is_l1;
                port_en = 1'b1;
                if (older_is_l1) begin
                    l1_rdata = rbuf;
                    l0_rdata = Data_in;
                end else begin
                    l0_rdata = rbuf;
                    l1_rdata = Data_in;
                end
                if (!stop_in) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Gated by rst_n so a reset drops the stall immediately even while
    // the lanes keep presenting their (to-be-replayed) requests.
    assign stall_out    = stall & rst_n;
    assign conflict_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            rbuf  <= '0;
            cnt_q <= DATA_INITIAL;
        end else begin
            state <= state_nxt;
            if (capture) begin
                rbuf  <= Data_in;
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    dm_port_mux #(.AW(AW), .DW(DW)) u_mux (
        .en       (port_en),
        .sel      (grant),
        .l0_we    (l0_we),
        .l0_wea   (l0_wea),
        .l0_addr  (l0_addr),
        .l0_wdata (l0_wdata),
        .l1_we    (l1_we),
        .l1_wea   (l1_wea),
        .l1_addr  (l1_addr),
        .l1_wdata (l1_wdata),
        .mem_w    (mem_w),
        .DWea     (DWea),
        .Addr_out (Addr_out),
        .Data_out (Data_out)
    );

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
//   Drives lane access pairs into dm_port_arbiter against a word memory,
//   predicts every cycle's port activity, stall, read words and counter
//   from the ordering rules, and compares in a separate monitor.
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stop_in = 1'b0;
  logic        l0_req = 1'b0, l1_req = 1'b0;
  logic        l0_we = 1'b0, l1_we = 1'b0;
  logic [3:0]  l0_wea = '0, l1_wea = '0;
  logic [31:0] l0_addr = '0, l1_addr = '0;
  logic [31:0] l0_wdata = '0, l1_wdata = '0;
  logic        l0_num = 1'b0, l1_num = 1'b0;
  logic        mem_w;
  logic [3:0]  DWea;
  logic [31:0] Addr_out, Data_out, Data_in;
  logic [31:0] l0_rdata, l1_rdata;
  logic        stall_out;
  logic [31:0] conflict_cnt;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  wea;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        num;
  } lane_t;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic        mw;
    logic [3:0]  wea;
    logic [31:0] wdata;
    logic        wd_chk;
    logic        stall;
    logic [31:0] r0;
    logic        r0_chk;
    logic [31:0] r1;
    logic        r1_chk;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_cnt = '0;
  int          checks = 0;
  int          errors = 0;
  int          rec_id = 0;

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign Data_in = tb_mem[Addr_out[9:2]];

  always @(posedge clk) begin
    if (mem_w)
      for (int b = 0; b < 4; b++)
        if (DWea[b]) tb_mem[Addr_out[9:2]][b*8 +: 8] <= Data_out[b*8 +: 8];
  end

  dm_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stop_in      (stop_in),
    .l0_req       (l0_req),
    .l0_we        (l0_we),
    .l0_wea       (l0_wea),
    .l0_addr      (l0_addr),
    .l0_wdata     (l0_wdata),
    .l0_num       (l0_num),
    .l1_req       (l1_req),
    .l1_we        (l1_we),
    .l1_wea       (l1_wea),
    .l1_addr      (l1_addr),
    .l1_wdata     (l1_wdata),
    .l1_num       (l1_num),
    .mem_w        (mem_w),
    .DWea         (DWea),
    .Addr_out     (Addr_out),
    .Data_out     (Data_out),
    .Data_in      (Data_in),
    .l0_rdata     (l0_rdata),
    .l1_rdata     (l1_rdata),
    .stall_out    (stall_out),
    .conflict_cnt (conflict_cnt)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (rec %0d): got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_lanes(input lane_t a, input lane_t b);
    l0_req = a.req; l0_we = a.we; l0_wea = a.wea; l0_addr = a.addr; l0_wdata = a.wdata; l0_num = a.num;
    l1_req = b.req; l1_we = b.we; l1_wea = b.wea; l1_addr = b.addr; l1_wdata = b.wdata; l1_num = b.num;
  endtask

  task automatic ref_store(input lane_t l);
    for (int b = 0; b < 4; b++)
      if (l.wea[b]) ref_mem[l.addr[9:2]][b*8 +: 8] = l.wdata[b*8 +: 8];
  endtask

  function automatic exp_t port_rec(input lane_t l, input logic stall);
    exp_t e;
    e.id = 0; e.addr = l.addr; e.mw = l.we; e.wea = l.we ? l.wea : 4'h0;
    e.wdata = l.wdata; e.wd_chk = l.we; e.stall = stall;
    e.r0 = '0; e.r0_chk = 1'b1; e.r1 = '0; e.r1_chk = 1'b1; e.cnt = '0;
    return e;
  endfunction

  // Expected read word of the lane at index 'lane' (store lanes are unchecked).
  task automatic set_r(inout exp_t e, input logic lane, input logic [31:0] v, input logic chk_en);
    if (lane) begin e.r1 = v; e.r1_chk = chk_en; end
    else      begin e.r0 = v; e.r0_chk = chk_en; end
  endtask

  // Hold one expected cycle for s stopped cycles plus the advancing one.
  task automatic emit(input exp_t e, input int s);
    for (int c = 0; c <= s; c++) begin
      stop_in = (c < s);
      e.id = rec_id++;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      tick();
    end
  endtask

  // ---------------- reference model / driver ----------------
  task automatic do_txn(input lane_t a, input lane_t b, input int s1, input int s2);
    exp_t  e;
    lane_t o, y;
    logic  o_is_1;
    logic [31:0] old_val;
    apply_lanes(a, b);
    if (!a.req && !b.req) begin
      e = port_rec('0, 1'b0);
      e.wd_chk = 1'b1;
      emit(e, s1);
    end else if (a.req != b.req) begin
      o = a.req ? a : b;
      e = port_rec(o, 1'b0);
      set_r(e, b.req, ref_mem[o.addr[9:2]], !o.we);
      emit(e, s1);
      if (o.we) ref_store(o);
    end else begin
      // Older = the lane with num 0; equal nums favour lane 0.
      o_is_1 = (a.num == 1'b1) && (b.num == 1'b0);
      o = o_is_1 ? b : a;
      y = o_is_1 ? a : b;
      e = port_rec(o, 1'b1);
      set_r(e, o_is_1, ref_mem[o.addr[9:2]], !o.we);
      emit(e, s1);
      old_val = ref_mem[o.addr[9:2]];
      if (o.we) ref_store(o);
      exp_cnt = (exp_cnt == 32'hFFFF_FFFF) ? exp_cnt : exp_cnt + 32'd1;
      e = port_rec(y, 1'b0);
      set_r(e, o_is_1, old_val, !o.we);
      set_r(e, !o_is_1, ref_mem[y.addr[9:2]], !y.we);
      emit(e, s2);
      if (y.we) ref_store(y);
    end
    apply_lanes('0, '0);
    stop_in = 1'b0;
  endtask

  function automatic lane_t rand_lane();
    lane_t l;
    l.req   = ($urandom_range(0, 3) != 0);
    l.we    = 1'($urandom_range(0, 1));
    l.wea   = 4'($urandom_range(0, 15));
    if (l.we && l.wea == 4'h0) l.wea = 4'h1;
    l.addr  = 32'($urandom_range(0, 7)) << 2;
    l.wdata = $urandom;
    l.num   = 1'($urandom_range(0, 1));
    return l;
  endfunction

  function automatic lane_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic num);
    lane_t l;
    l.req = 1'b1; l.we = we; l.wea = we ? 4'hF : 4'h0; l.addr = addr; l.wdata = wd; l.num = num;
    return l;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("addr_out", e.id, Addr_out, e.addr);
        chk("mem_w", e.id, {31'b0, mem_w}, {31'b0, e.mw});
        chk("dwea", e.id, {28'b0, DWea}, {28'b0, e.wea});
        if (e.wd_chk) chk("data_out", e.id, Data_out, e.wdata);
        chk("stall_out", e.id, {31'b0, stall_out}, {31'b0, e.stall});
        if (e.r0_chk) chk("l0_rdata", e.id, l0_rdata, e.r0);
        if (e.r1_chk) chk("l1_rdata", e.id, l1_rdata, e.r1);
        chk("conflict_cnt", e.id, conflict_cnt, e.cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    lane_t a, b;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    #2;
    chk("reset_state", -1, {31'b0, dut.state}, {31'b0, ARB_IDLE});
    chk("reset_stall", -1, {31'b0, stall_out}, 32'h0);
    chk("reset_cnt", -1, conflict_cnt, 32'h0);
    chk("reset_addr", -1, Addr_out, 32'h0);
    chk("reset_mem_w", -1, {31'b0, mem_w}, 32'h0);
    #10 rst_n = 1'b1;
    tick();

    // Single load from 0x100.
    tb_mem[64] = 32'hDEADBEEF; ref_mem[64] = 32'hDEADBEEF;
    do_txn('0, mk(1'b0, 32'h100, 32'h0, 1'b0), 0, 0);
    // Conflict: older lane 1 stores, younger lane 0 loads the same word.
    do_txn(mk(1'b0, 32'h40, 32'h0, 1'b1), mk(1'b1, 32'h40, 32'h12345678, 1'b0), 0, 0);
    // Conflict: older load, younger store to the same word.
    tb_mem[32] = 32'hAAAA5555; ref_mem[32] = 32'hAAAA5555;
    do_txn(mk(1'b0, 32'h80, 32'h0, 1'b0), mk(1'b1, 32'h80, 32'hCAFEF00D, 1'b1), 0, 0);
    chk("mem_after_store", -1, tb_mem[32], 32'hCAFEF00D);
    // Stores in both slots with 3 frozen cycles in each state.
    do_txn(mk(1'b1, 32'h0C, 32'h01020304, 1'b0), mk(1'b1, 32'h10, 32'hA0B0C0D0, 1'b1), 3, 3);
    chk("stop_store0", -1, tb_mem[3], 32'h01020304);
    chk("stop_store1", -1, tb_mem[4], 32'hA0B0C0D0);
    // Tie on num: lane 0 first.
    do_txn(mk(1'b1, 32'h14, 32'h5A5A5A5A, 1'b0), mk(1'b0, 32'h14, 32'h0, 1'b0), 0, 0);

    // Randomised traffic.
    for (int n = 0; n < 200; n++) begin
      a = rand_lane();
      b = rand_lane();
      do_txn(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Saturation of the conflict counter.
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    do_txn(mk(1'b0, 32'h04, 32'h0, 1'b0), mk(1'b0, 32'h08, 32'h0, 1'b1), 0, 0);
    do_txn(mk(1'b0, 32'h04, 32'h0, 1'b1), mk(1'b0, 32'h08, 32'h0, 1'b0), 0, 1);
    chk("cnt_saturated", -1, conflict_cnt, 32'hFFFF_FFFF);

    // Asynchronous reset while in SECOND, requests still held.
    apply_lanes(mk(1'b0, 32'h18, 32'h0, 1'b0), mk(1'b0, 32'h1C, 32'h0, 1'b1));
    stop_in = 1'b0;
    tick();
    stop_in = 1'b1;
    tick();
    chk("in_second", -1, {31'b0, dut.state}, {31'b0, ARB_SECOND});
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", -1, {31'b0, dut.state}, {31'b0, ARB_IDLE});
    chk("arst_stall", -1, {31'b0, stall_out}, 32'h0);
    chk("arst_cnt", -1, conflict_cnt, 32'h0);
    chk("arst_rbuf", -1, dut.rbuf, 32'h0);
    tick();
    apply_lanes('0, '0);
    stop_in = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
    tick();
    // Lanes replay after reset.
    do_txn(mk(1'b0, 32'h18, 32'h0, 1'b0), mk(1'b0, 32'h1C, 32'h0, 1'b1), 0, 0);
    for (int n = 0; n < 20; n++) do_txn(rand_lane(), rand_lane(), 0, 0);

    tick();
    chk("queue_drained", -1, 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the single data-memory port between the two parallel execution lanes of the dual-issue core. Sits at the memory stage, between the lanes' second-stage pipeline registers and the data memory. It serialises same-cycle accesses in program order (oldest first), stalls the pipeline for the extra cycle, and returns each lane's raw read word. Sign extension stays in the lanes.

## Interface
Parameters:
- AW, 32, memory address width
- DW, 32, data width; byte enables are DW/8 = 4 bits

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- stop_in  in  1  external pipeline freeze (same source as the lanes' stop)
- l0_req / l1_req  in  1  lane has a load or store this cycle
- l0_we / l1_we  in  1  store when 1, load when 0
- l0_wea / l1_wea  in  4  byte write enables, already shifted by addr[1:0]
- l0_addr / l1_addr  in  AW  byte address
- l0_wdata / l1_wdata  in  DW  store data
- l0_num / l1_num  in  1  issue-order bit; 0 = older
- mem_w  out  1  memory write strobe
- DWea  out  4  memory byte enables
- Addr_out  out  AW  memory address
- Data_out  out  DW  memory write data
- Data_in  in  DW  memory read data, combinational from Addr_out
- l0_rdata / l1_rdata  out  DW  raw read word per lane
- stall_out  out  1  arbitration stall request to the pipeline
- conflict_cnt  out  32  saturating count of conflict serialisations

## Operation
- Older lane: lane with num = 0. If both num bits are equal, lane 0 is older.
- FSM states:
  - IDLE: reset state.
  - SECOND: the older lane's access is done; the younger lane's access is pending.
- IDLE, 0 requests: port idle; mem_w = 0, DWea = 0, Addr_out = 0, Data_out = 0.
- IDLE, exactly 1 request: that lane drives the port directly; stall_out = 0.
- IDLE, both requesting:
  - The older lane drives the port; stall_out = 1.
  - If stop_in = 0: capture Data_in into rbuf (the older lane's result), go to SECOND, increment conflict_cnt (saturate at 0xFFFF_FFFF).
  - If stop_in = 1: stay in IDLE, no capture, no count. Re-driving the older access is idempotent.
- SECOND:
  - The younger lane drives the port; stall_out = 0.
  - Older lane's rdata = rbuf. Younger lane's rdata = Data_in.
  - If stop_in = 0: go to IDLE. If stop_in = 1: hold SECOND and rbuf.
- Non-SECOND rdata: a lane currently driving the port gets Data_in. A lane not driving the port gets 0.
- For a load, mem_w = 0 and DWea = 0. For a store, mem_w = 1 and DWea = the lane's wea.
- rdata of a store lane is don't-care.
- Lanes' inputs are held stable by the pipeline while stall_out or stop_in is high. The block does not re-register them.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, rbuf = 0, conflict_cnt = 0, stall_out = 0. Port outputs are 0 as long as no request is present.
- Single access: zero added latency. The port is driven combinationally in the request cycle, and rdata is valid in the same cycle.
- Conflict pair with stop_in low:
  - Cycle N: older access, stall_out = 1.
  - Cycle N+1: younger access, stall_out = 0; both rdata are valid; the pipeline advances at the end of N+1.
- Every stop_in-high cycle extends the current state by one cycle with identical port outputs.
- Stores are never performed twice across different states. An older-load / younger-store pair to the same address returns the pre-store value to the older lane.
- rst_n asserted in SECOND aborts the younger access; the lanes replay after reset.

## Structure
- Shared definitions header (existing def.vh): DATA_BUS, MEM_ADDR_BUS, DMWRITE_DISABLE, DATA_INITIAL, and the new state encodings ARB_IDLE and ARB_SECOND.
- Sub-module dm_port_mux: purely combinational selection of one lane's request onto the port, selected by a 1-bit grant. The parent holds the FSM, rbuf, the stall logic and the counter.

## Test plan
- Reset: hold rst_n low mid-SECOND -> state IDLE, stall_out = 0, conflict_cnt = 0, rbuf = 0 immediately, with no clock edge needed.
- Single load: l1_req = 1, l1_we = 0, l1_addr = 0x100, memory word 0xDEADBEEF -> l1_rdata = 0xDEADBEEF in the same cycle; stall_out = 0.
- Conflict, store then load: l0 (num = 1) loads 0x40; l1 (num = 0) stores 0x12345678 to 0x40 with wea = 4'b1111.
  - Cycle N: port shows l1's write, stall_out = 1.
  - Cycle N+1: port shows l0's read; l0_rdata = 0x12345678; conflict_cnt = 1.
- Conflict, load then store at the same address (older load, initial word 0xAAAA5555) -> older lane's rdata = 0xAAAA5555 at N+1; memory holds the stored value afterwards.
- stop_in high for 3 cycles during the conflict, once in IDLE and once in SECOND -> the write strobe for each store occurs only in its own state; conflict_cnt increments once; results match the no-stop case.
- Tie order: both num = 0 and both requesting -> lane 0 is served first; conflict_cnt saturates at 0xFFFF_FFFF when preloaded via force.
